if_fetch_ctrl: RTL and testbench

IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

---
 rtl/if_fetch_ctrl_if.sv | 28 ++
 rtl/if_fetch_ctrl.sv | 118 +++++++++++
 tb/tb_if_fetch_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/if_fetch_ctrl_if.sv
// Bundle between the IF fetch controller, the IF/ID pipeline and instruction memory.
// master: the fetch controller; slave: pipeline registers and memory around it.
interface if_fetch_ctrl_if;
   logic          if_valid_i;
   logic [63:0]   pc_ibus;
   logic          if_allowin_o;
   logic          excep_flush_i;
   logic          inst_req_o;
   logic [31:0]   inst_addr_o;
   logic          inst_addr_ok_i;
   logic          inst_data_ok_i;
   logic [63:0]   inst_rdata_i;
   logic          id_allowin_i;
   logic          if_to_id_valid_o;
   logic [128:0]  to_id_obus;

   modport master (
      input  if_valid_i, pc_ibus, excep_flush_i, inst_addr_ok_i, inst_data_ok_i,
      input  inst_rdata_i, id_allowin_i,
      output if_allowin_o, inst_req_o, inst_addr_o, if_to_id_valid_o, to_id_obus
   );

   modport slave (
      output if_valid_i, pc_ibus, excep_flush_i, inst_addr_ok_i, inst_data_ok_i,
      output inst_rdata_i, id_allowin_i,
      input  if_allowin_o, inst_req_o, inst_addr_o, if_to_id_valid_o, to_id_obus
   );
endinterface

// File: rtl/if_fetch_ctrl.sv
// IF stage fetch controller: issues one instruction-pair request per PC and forwards it to ID.
// Define IF_ADEF_CHECK_EN to flag misaligned pc1 as an address fault instead of fetching it.
module if_fetch_ctrl (
   input  logic          clk,
   input  logic          rst_n,
   if_fetch_ctrl_if.master bus
);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

   state_e       state_q, state_d;
   logic         cancel_q, cancel_d;
   logic [31:0]  addr_q, addr_d;
   logic [63:0]  buf_q, buf_d;

   logic [31:0]  pc1, pc2;
   logic         adef;
   logic         live;
   logic         issue;
   logic         valid;
   logic [63:0]  insts;

   assign pc1 = bus.pc_ibus[31:0];
   assign pc2 = bus.pc_ibus[63:32];

`ifdef IF_ADEF_CHECK_EN
   assign adef = (pc1[1:0] != 2'b00);
`else
   assign adef = 1'b0;
`endif

   assign live  = bus.if_valid_i & ~bus.excep_flush_i & ~cancel_q;
   assign issue = live & ~adef;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         cancel_q <= 1'b0;
         addr_q   <= 32'h0;
         buf_q    <= 64'h0;
      end else begin
         state_q  <= state_d;
         cancel_q <= cancel_d;
         addr_q   <= addr_d;
         buf_q    <= buf_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cancel_d = cancel_q;
      addr_d   = addr_q;
      buf_d    = buf_q;
      unique case (state_q)
         StIdle: begin
            if (issue) begin
               addr_d  = pc1;
               state_d = bus.inst_addr_ok_i ? StWait : StReq;
            end
         end
         StReq: begin
            // An issued request cannot be withdrawn; remember to drop its data instead.
            if (bus.excep_flush_i) cancel_d = 1'b1;
            if (bus.inst_addr_ok_i) state_d = StWait;
         end
         StWait: begin
            if (bus.inst_data_ok_i) begin
               cancel_d = 1'b0;
               if (cancel_q || bus.excep_flush_i || !bus.if_valid_i) begin
                  state_d = StIdle;
               end else if (bus.id_allowin_i) begin
                  state_d = StIdle;
               end else begin
                  state_d = StHold;
                  buf_d   = bus.inst_rdata_i;
               end
            end else if (bus.excep_flush_i) begin
               cancel_d = 1'b1;
            end
         end
         StHold: begin
            if (bus.excep_flush_i || !bus.if_valid_i || bus.id_allowin_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.inst_req_o  = 1'b0;
      bus.inst_addr_o = addr_q;
      valid           = 1'b0;
      insts           = bus.inst_rdata_i;
      unique case (state_q)
         StIdle: begin
            bus.inst_req_o  = issue;
            bus.inst_addr_o = pc1;
            valid           = live & adef;
         end
         StReq:  bus.inst_req_o = 1'b1;
         StWait: valid = live & bus.inst_data_ok_i;
         StHold: begin
            valid = live;
            insts = buf_q;
         end
         default: ;
      endcase
      if (adef) insts = 64'h0;
      // Reset must silence the memory side even though the FSM already reads as idle.
      if (!rst_n) begin
         bus.inst_req_o = 1'b0;
         valid          = 1'b0;
      end
      bus.if_to_id_valid_o = valid;
      bus.if_allowin_o     = ~bus.if_valid_i | (valid & bus.id_allowin_i);
      bus.to_id_obus       = {adef, insts[63:32], pc2, insts[31:0], pc1};
   end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed self-checking bench for if_fetch_ctrl; expectations follow IF_ADEF_CHECK_EN.
module tb_if_fetch_ctrl;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   if_fetch_ctrl_if bus ();

   if_fetch_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [128:0] obs, input logic [128:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs at the falling edge, settle, then let the caller check.
   task automatic drive(input logic v, input logic [63:0] pc, input logic fl, input logic ao,
                        input logic dok, input logic [63:0] rd, input logic ida);
      @(negedge clk);
      bus.if_valid_i     = v;
      bus.pc_ibus        = pc;
      bus.excep_flush_i  = fl;
      bus.inst_addr_ok_i = ao;
      bus.inst_data_ok_i = dok;
      bus.inst_rdata_i   = rd;
      bus.id_allowin_i   = ida;
      #1;
   endtask

   localparam logic [63:0] P1 = {32'h1c000004, 32'h1c000000};
   localparam logic [63:0] R1 = {32'h02800c0c, 32'h0380000d};
   localparam logic [63:0] P2 = {32'h1c00000c, 32'h1c000008};
   localparam logic [63:0] R2 = {32'h11112222, 32'h33334444};
   localparam logic [63:0] P3 = {32'h1c000014, 32'h1c000010};
   localparam logic [63:0] P4 = {32'h1c000104, 32'h1c000100};
   localparam logic [63:0] P5 = {32'h1c000204, 32'h1c000200};
   localparam logic [63:0] R5 = {32'haaaa5555, 32'h12345678};
   localparam logic [63:0] PA = {32'h1c000006, 32'h1c000002};
   localparam logic [63:0] JUNK = 64'hdeadbeef_cafef00d;

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      bus.if_valid_i     = 1'b1;
      bus.pc_ibus        = P1;
      bus.excep_flush_i  = 1'b0;
      bus.inst_addr_ok_i = 1'b0;
      bus.inst_data_ok_i = 1'b0;
      bus.inst_rdata_i   = 64'h0;
      bus.id_allowin_i   = 1'b1;
      #3;
      check("rst_req", bus.inst_req_o, 1'b0);
      check("rst_valid", bus.if_to_id_valid_o, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic fetch: addr_ok in cycle 0, data_ok in cycle 2, bypassed straight to ID.
      drive(1, P1, 0, 1, 0, JUNK, 1);
      check("t1_req", bus.inst_req_o, 1'b1);
      check("t1_addr", bus.inst_addr_o, 32'h1c000000);
      check("t1_allowin0", bus.if_allowin_o, 1'b0);
      drive(1, P1, 0, 0, 0, JUNK, 1);
      check("t1_wait_req", bus.inst_req_o, 1'b0);
      check("t1_wait_valid", bus.if_to_id_valid_o, 1'b0);
      drive(1, P1, 0, 0, 1, R1, 1);
      check("t1_valid", bus.if_to_id_valid_o, 1'b1);
      check("t1_obus", bus.to_id_obus,
            {1'b0, 32'h02800c0c, 32'h1c000004, 32'h0380000d, 32'h1c000000});
      check("t1_allowin", bus.if_allowin_o, 1'b1);

      // ID stalls: data held in the buffer, output stable.
      drive(1, P2, 0, 1, 0, JUNK, 0);
      check("t2_req", bus.inst_req_o, 1'b1);
      drive(1, P2, 0, 0, 1, R2, 0);
      check("t2_valid", bus.if_to_id_valid_o, 1'b1);
      check("t2_allowin", bus.if_allowin_o, 1'b0);
      for (int i = 0; i < 2; i++) begin
         drive(1, P2, 0, 0, 0, JUNK, 0);
         check("t2_hold_valid", bus.if_to_id_valid_o, 1'b1);
         check("t2_hold_obus", bus.to_id_obus,
               {1'b0, 32'h11112222, 32'h1c00000c, 32'h33334444, 32'h1c000008});
      end
      drive(1, P2, 0, 0, 0, JUNK, 1);
      check("t2_accept", bus.if_allowin_o, 1'b1);
      check("t2_accept_obus", bus.to_id_obus,
            {1'b0, 32'h11112222, 32'h1c00000c, 32'h33334444, 32'h1c000008});

      // Back in IDLE: a new PC is requested immediately; no addr_ok yet so enter REQ.
      drive(1, P3, 0, 0, 0, JUNK, 1);
      check("t3_idle_req", bus.inst_req_o, 1'b1);
      check("t3_idle_addr", bus.inst_addr_o, 32'h1c000010);
      // Flush while in REQ: request is held at the old address.
      drive(1, P3, 1, 0, 0, JUNK, 1);
      check("t3_flush_req", bus.inst_req_o, 1'b1);
      check("t3_flush_valid", bus.if_to_id_valid_o, 1'b0);
      drive(1, P4, 0, 0, 0, JUNK, 1);
      check("t3_held_addr", bus.inst_addr_o, 32'h1c000010);
      drive(1, P4, 0, 1, 0, JUNK, 1);
      check("t3_ok_addr", bus.inst_addr_o, 32'h1c000010);
      drive(1, P4, 0, 0, 1, R1, 1);
      check("t3_stale_valid", bus.if_to_id_valid_o, 1'b0);
      drive(1, P4, 0, 1, 0, JUNK, 1);
      check("t3_new_req", bus.inst_req_o, 1'b1);
      check("t3_new_addr", bus.inst_addr_o, 32'h1c000100);

      // Flush coincident with data_ok: data dropped, no cancel left behind.
      drive(1, P4, 1, 0, 1, R1, 1);
      check("t4_valid", bus.if_to_id_valid_o, 1'b0);
      drive(1, P5, 0, 1, 0, JUNK, 1);
      check("t4_next_req", bus.inst_req_o, 1'b1);
      check("t4_next_addr", bus.inst_addr_o, 32'h1c000200);

      // Flush in WAIT before data: the late data is discarded, then refetch.
      drive(1, P5, 1, 0, 0, JUNK, 1);
      check("t5_flush_valid", bus.if_to_id_valid_o, 1'b0);
      drive(1, P5, 0, 0, 1, R1, 1);
      check("t5_stale_valid", bus.if_to_id_valid_o, 1'b0);
      drive(1, P5, 0, 1, 0, JUNK, 1);
      check("t5_refetch_req", bus.inst_req_o, 1'b1);
      drive(1, P5, 0, 0, 1, R5, 1);
      check("t5_obus", bus.to_id_obus,
            {1'b0, 32'haaaa5555, 32'h1c000204, 32'h12345678, 32'h1c000200});
      check("t5_valid", bus.if_to_id_valid_o, 1'b1);

      // Flush in IDLE: nothing issued.
      drive(1, P5, 1, 1, 0, JUNK, 1);
      check("t6_flush_idle_req", bus.inst_req_o, 1'b0);

      // Misaligned pc1.
      drive(1, PA, 0, 0, 0, JUNK, 1);
`ifdef IF_ADEF_CHECK_EN
      check("t7_adef_req", bus.inst_req_o, 1'b0);
      check("t7_adef_valid", bus.if_to_id_valid_o, 1'b1);
      check("t7_adef_obus", bus.to_id_obus,
            {1'b1, 32'h0, 32'h1c000006, 32'h0, 32'h1c000002});
`else
      check("t7_req", bus.inst_req_o, 1'b1);
      check("t7_addr", bus.inst_addr_o, 32'h1c000002);
      check("t7_valid", bus.if_to_id_valid_o, 1'b0);
`endif
      drive(0, PA, 0, 0, 0, JUNK, 1);

      // Asynchronous reset in WAIT: outputs drop immediately, FSM restarts in IDLE.
      // (Without the check macro the misaligned request above left the FSM in REQ.)
      drive(1, P1, 0, 1, 0, JUNK, 1);
      drive(1, P1, 0, 0, 0, JUNK, 1);
      check("t8_wait_req", bus.inst_req_o, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("t8_rst_req", bus.inst_req_o, 1'b0);
      check("t8_rst_valid", bus.if_to_id_valid_o, 1'b0);
      drive(1, P1, 0, 0, 0, JUNK, 1);
      rst_n = 1'b1;
      #1;
      check("t8_after_req", bus.inst_req_o, 1'b1);
      check("t8_after_addr", bus.inst_addr_o, 32'h1c000000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
